se_pool_reader: RTL and testbench

Read sequencer for the pooling BRAM's 4-wide SE read port. On `start` it walks `ceil(num_ch/4)` channel groups from `base_addr`, stepping the read address by 4. It absorbs the BRAM's registered-read latency and emits one 4-lane group per valid/ready handshake to the squeeze-excitation datapath. Lanes beyond `num_ch` are masked, the last group is flagged, and `done` pulses at the end.

---
 rtl/se_pool_reader.sv | 207 ++++++++++++++++++++
 tb/tb_se_pool_reader.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/se_pool_reader.sv
// se_pool_reader: read sequencer for the pooling BRAM's 4-wide SE port.
// Walks ceil(num_ch/4) groups and streams them out over valid/ready.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   start               one-cycle request, sampled in IDLE only
//   base_addr, num_ch   job parameters, sampled with start
//   bram_rd_addr        registered BRAM read address (steps by 4)
//   bram_data_0..3      BRAM read data, one cycle after the address
//   out_valid/ready     group handshake
//   out_data_0..3       group lanes (masked lanes forced to 0)
//   out_mask, out_last  lane-valid bits, final-group flag
//   busy, done          job active, end-of-job pulse
module se_pool_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 20,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [CNT_WIDTH-1:0]  num_ch,
    output logic [ADDR_WIDTH-1:0] bram_rd_addr,
    input  logic [DATA_WIDTH-1:0] bram_data_0,
    input  logic [DATA_WIDTH-1:0] bram_data_1,
    input  logic [DATA_WIDTH-1:0] bram_data_2,
    input  logic [DATA_WIDTH-1:0] bram_data_3,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data_0,
    output logic [DATA_WIDTH-1:0] out_data_1,
    output logic [DATA_WIDTH-1:0] out_data_2,
    output logic [DATA_WIDTH-1:0] out_data_3,
    output logic [3:0]            out_mask,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    localparam int RW = CNT_WIDTH + 2;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH
    } state_t;

    state_t state;

    logic [CNT_WIDTH-1:0] num_q;
    logic [CNT_WIDTH-1:0] groups;
    logic [CNT_WIDTH-1:0] issued;
    logic [CNT_WIDTH-1:0] cap_g;

    // v_addr: address register holds an issued read.
    // v_data: BRAM output register holds its data.
    logic v_addr;
    logic v_data;

    logic [DATA_WIDTH-1:0] fifo_data [4][4];
    logic [3:0]            fifo_mask [4];
    logic                  fifo_last [4];
    logic [1:0]            wr_ptr;
    logic [1:0]            rd_ptr;
    logic [2:0]            fifo_count;

    logic [2:0]            inflight;
    logic [2:0]            occ;
    logic                  can_issue;
    logic                  push;
    logic                  pop;
    logic [RW-1:0]         rem;
    logic [3:0]            cap_mask;
    logic                  cap_last;
    logic [DATA_WIDTH-1:0] bram_lane [4];
    logic [CNT_WIDTH:0]    groups_calc;

    assign bram_lane[0] = bram_data_0;
    assign bram_lane[1] = bram_data_1;
    assign bram_lane[2] = bram_data_2;
    assign bram_lane[3] = bram_data_3;

    assign groups_calc = ({1'b0, num_ch} + (CNT_WIDTH+1)'(3)) >> 2;

    assign inflight = {2'b00, v_addr} + {2'b00, v_data};
    assign occ      = fifo_count + inflight;

    // Counting in-flight reads against FIFO space keeps the FIFO
    // from ever overflowing, whatever the consumer does.
    assign can_issue = (state == RUN)
                    && (issued < groups)
                    && (occ < 3'd4);

    assign push      = v_data;
    assign out_valid = (fifo_count != 3'd0);
    assign pop       = out_valid && out_ready;

    // Channels remaining from the group being captured.
    assign rem = {2'b00, num_q} - {cap_g, 2'b00};

    assign cap_mask[0] = (rem > RW'(0));
    assign cap_mask[1] = (rem > RW'(1));
    assign cap_mask[2] = (rem > RW'(2));
    assign cap_mask[3] = (rem > RW'(3));

    assign cap_last = (cap_g == groups - CNT_WIDTH'(1));

    assign out_data_0 = fifo_data[rd_ptr][0];
    assign out_data_1 = fifo_data[rd_ptr][1];
    assign out_data_2 = fifo_data[rd_ptr][2];
    assign out_data_3 = fifo_data[rd_ptr][3];
    assign out_mask   = fifo_mask[rd_ptr];
    assign out_last   = fifo_last[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            num_q        <= '0;
            groups       <= '0;
            issued       <= '0;
            cap_g        <= '0;
            v_addr       <= 1'b0;
            v_data       <= 1'b0;
            bram_rd_addr <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_count   <= '0;
            for (int e = 0; e < 4; e++) begin
                fifo_mask[e] <= '0;
                fifo_last[e] <= 1'b0;
                for (int l = 0; l < 4; l++) begin
                    fifo_data[e][l] <= '0;
                end
            end
        end else begin
            v_data <= v_addr;
            v_addr <= 1'b0;
            done   <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (start) begin
                        num_q  <= num_ch;
                        groups <= groups_calc[CNT_WIDTH-1:0];
                        cap_g  <= '0;
                        if (num_ch == '0) begin
                            issued <= '0;
                            state  <= FINISH;
                            done   <= 1'b1;
                        end else begin
                            // First read goes out with start so
                            // the address is valid right after it.
                            bram_rd_addr <= base_addr;
                            issued       <= CNT_WIDTH'(1);
                            v_addr       <= 1'b1;
                            busy         <= 1'b1;
                            state        <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (can_issue) begin
                        bram_rd_addr <= bram_rd_addr
                                      + ADDR_WIDTH'(4);
                        issued       <= issued + CNT_WIDTH'(1);
                        v_addr       <= 1'b1;
                    end
                    if (pop && out_last) begin
                        state <= FINISH;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                FINISH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if (push) begin
                for (int l = 0; l < 4; l++) begin
                    fifo_data[wr_ptr][l] <= cap_mask[l]
                                          ? bram_lane[l]
                                          : '0;
                end
                fifo_mask[wr_ptr] <= cap_mask;
                fifo_last[wr_ptr] <= cap_last;
                wr_ptr            <= wr_ptr + 2'd1;
                cap_g             <= cap_g + CNT_WIDTH'(1);
            end

            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end

            fifo_count <= fifo_count
                        + {2'b00, push}
                        - {2'b00, pop};
        end
    end

endmodule

// File: tb/tb_se_pool_reader.sv
// Testbench for se_pool_reader: table of jobs plus hand-written
// sequences for reset state and reset in the middle of a job.
module tb_se_pool_reader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [19:0] base_addr;
    logic [15:0] num_ch;
    logic [19:0] bram_rd_addr;
    logic [31:0] bram_data_0;
    logic [31:0] bram_data_1;
    logic [31:0] bram_data_2;
    logic [31:0] bram_data_3;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data_0;
    logic [31:0] out_data_1;
    logic [31:0] out_data_2;
    logic [31:0] out_data_3;
    logic [3:0]  out_mask;
    logic        out_last;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;

    se_pool_reader dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .base_addr    (base_addr),
        .num_ch       (num_ch),
        .bram_rd_addr (bram_rd_addr),
        .bram_data_0  (bram_data_0),
        .bram_data_1  (bram_data_1),
        .bram_data_2  (bram_data_2),
        .bram_data_3  (bram_data_3),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data_0   (out_data_0),
        .out_data_1   (out_data_1),
        .out_data_2   (out_data_2),
        .out_data_3   (out_data_3),
        .out_mask     (out_mask),
        .out_last     (out_last),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM model: registered read, content of word a is a.
    always @(posedge clk) begin
        bram_data_0 <= 32'(bram_rd_addr) + 32'd0;
        bram_data_1 <= 32'(bram_rd_addr) + 32'd1;
        bram_data_2 <= 32'(bram_rd_addr) + 32'd2;
        bram_data_3 <= 32'(bram_rd_addr) + 32'd3;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1);
    end

    typedef struct {
        logic [19:0] base;
        logic [15:0] num;
        int          mode;
        logic        poke;
        int          exp_groups;
        logic [3:0]  exp_last_mask;
        logic [31:0] exp_last_d0;
    } vec_t;

    task automatic check(input string name,
                         input logic [127:0] act,
                         input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic ready_at(input int mode, input int k);
        if (mode == 0) return 1'b1;
        return ((k % 4) == 0) || ((k % 4) == 3);
    endfunction

    task automatic run_job(input vec_t v);
        int          k;
        int          got;
        int          first_v;
        int          first_hs;
        int          last_hs;
        int          max_occ;
        int          occ;
        logic        fin;
        logic        stall;
        logic        quiet;
        logic [127:0] held_d;
        logic [3:0]   held_m;
        logic [127:0] exp_d;
        logic [3:0]   exp_m;
        logic [19:0]  a;
        logic [19:0]  prev_addr;
        int           ch;

        prev_addr = bram_rd_addr;
        @(negedge clk);
        start     = 1'b1;
        base_addr = v.base;
        num_ch    = v.num;
        out_ready = ready_at(v.mode, 0);
        @(negedge clk);
        start = 1'b0;
        k     = 1;

        if (v.num == 16'd0) begin
            check("zero_done", done, 1);
            check("zero_busy", busy, 0);
            check("zero_addr", bram_rd_addr, prev_addr);
            quiet = 1'b1;
            repeat (4) begin
                @(negedge clk);
                if (out_valid || busy || done) quiet = 1'b0;
            end
            check("zero_quiet", quiet, 1);
            return;
        end

        check("start_addr", bram_rd_addr, v.base);
        check("start_busy", busy, 1);

        got      = 0;
        fin      = 1'b0;
        stall    = 1'b0;
        first_v  = -1;
        first_hs = -1;
        last_hs  = -1;
        max_occ  = 0;
        held_d   = '0;
        held_m   = '0;

        while (!fin && k < 400) begin
            if (v.poke) begin
                start     = (k == 2);
                base_addr = 20'd999;
            end
            out_ready = ready_at(v.mode, k);

            occ = int'(dut.fifo_count) + int'(dut.v_addr)
                + int'(dut.v_data);
            if (occ > max_occ) max_occ = occ;

            if (stall) begin
                check("stall_data",
                      {out_data_0, out_data_1,
                       out_data_2, out_data_3}, held_d);
                check("stall_mask", out_mask, held_m);
            end

            if (out_valid && first_v < 0) first_v = k;

            if (out_valid && out_ready) begin
                if (got >= v.exp_groups) begin
                    check("extra_group", got, v.exp_groups - 1);
                    break;
                end
                a = v.base + 20'(4 * got);
                for (int i = 0; i < 4; i++) begin
                    ch = 4 * got + i;
                    exp_m[i] = (ch < int'(v.num));
                    exp_d[127-32*i -: 32] =
                        exp_m[i] ? 32'(a) + 32'(i) : 32'd0;
                end
                check("grp_data",
                      {out_data_0, out_data_1,
                       out_data_2, out_data_3}, exp_d);
                check("grp_mask", out_mask, exp_m);
                check("grp_last", out_last,
                      got == v.exp_groups - 1);
                if (got == v.exp_groups - 1) begin
                    check("last_mask_hand", out_mask,
                          v.exp_last_mask);
                    check("last_d0_hand", out_data_0,
                          v.exp_last_d0);
                end
                if (first_hs < 0) first_hs = k;
                last_hs = k;
                got++;
                if (out_last) fin = 1'b1;
            end

            stall  = out_valid && !out_ready;
            held_d = {out_data_0, out_data_1,
                      out_data_2, out_data_3};
            held_m = out_mask;

            @(negedge clk);
            k++;
        end
        start = 1'b0;

        check("job_finished", fin, 1);
        check("group_count", got, v.exp_groups);
        check("occupancy_le4", max_occ <= 4, 1);
        if (fin) begin
            check("done_pulse", done, 1);
            check("busy_end", busy, 0);
            if (v.mode == 0) begin
                check("first_valid_lat", first_v, 3);
                check("no_bubbles", last_hs - first_hs,
                      v.exp_groups - 1);
            end
            @(negedge clk);
            check("done_one_cycle", done, 0);
        end
    endtask

    vec_t vecs [6];
    vec_t after_rst;

    initial begin
        int hs;
        int k;

        vecs[0] = '{20'd100, 16'd8, 0, 1'b0, 2, 4'b1111, 32'd104};
        vecs[1] = '{20'd0, 16'd10, 0, 1'b0, 3, 4'b0011, 32'd8};
        vecs[2] = '{20'h200, 16'd32, 1, 1'b0, 8, 4'b1111,
                    32'h21C};
        vecs[3] = '{20'd300, 16'd0, 0, 1'b0, 0, 4'b0000, 32'd0};
        vecs[4] = '{20'hFFFFC, 16'd5, 0, 1'b0, 2, 4'b0001,
                    32'd0};
        vecs[5] = '{20'd40, 16'd12, 0, 1'b1, 3, 4'b1111, 32'd48};
        after_rst = '{20'h3000, 16'd6, 1, 1'b0, 2, 4'b0011,
                      32'h3004};

        rst_n     = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        num_ch    = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_addr", bram_rd_addr, 0);
        check("rst_mask", out_mask, 0);
        check("rst_last", out_last, 0);
        check("rst_data0", out_data_0, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int j = 0; j < 6; j++) begin
            run_job(vecs[j]);
            repeat (2) @(negedge clk);
        end

        // Reset after three handshakes of a 16-group job.
        start     = 1'b1;
        base_addr = 20'h1000;
        num_ch    = 16'd64;
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hs    = 0;
        k     = 0;
        while (hs < 3 && k < 50) begin
            if (out_valid && out_ready) hs++;
            @(negedge clk);
            k++;
        end
        check("mid_handshakes", hs, 3);
        check("mid_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_addr", bram_rd_addr, 0);
        check("mid_rst_data",
              {out_data_0, out_data_1, out_data_2, out_data_3},
              128'd0);
        check("mid_rst_mask", out_mask, 0);
        check("mid_rst_last", out_last, 0);
        check("mid_rst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_idle", busy | out_valid, 0);
        run_job(after_rst);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
